// File: rtl/pi_leibniz_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pi_leibniz_sequencer_if
//  Description : Start/operand/result bundle between the Leibniz sequencer
//                (master) and the calc_decimal divider (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface pi_leibniz_sequencer_if #(
    parameter int P_WIDTH_IN = 16
);
    logic                  div_start;
    logic [P_WIDTH_IN-1:0] div_numerator;
    logic [P_WIDTH_IN-1:0] div_denominator;
    logic                  div_done;
    logic [P_WIDTH_IN-1:0] div_decimal;

    modport master (
        output div_start,
        output div_numerator,
        output div_denominator,
        input  div_done,
        input  div_decimal
    );

    modport slave (
        input  div_start,
        input  div_numerator,
        input  div_denominator,
        output div_done,
        output div_decimal
    );
endinterface
`default_nettype wire

// File: rtl/pi_leibniz_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pi_leibniz_sequencer
//  Description : Computes pi with the Leibniz series by issuing one 1/(2k+1)
//                division per term to an attached calc_decimal divider and
//                folding the Q0.16 quotients into a Q1.16 pi/4 accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
module pi_leibniz_sequencer #(
    parameter int P_WIDTH_IN  = 16,
    parameter int P_NUM_TERMS = 100
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [18:0]            pi_out,
    output logic [15:0]            term_idx,
    pi_leibniz_sequencer_if.master div_if
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_ACCUM  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    // pi/4 == 1.0 in Q1.16: the k=0 term is preloaded instead of divided
    localparam logic [17:0]           c_acc_one = 18'h10000;
    localparam logic [15:0]           c_last_k  = 16'(P_NUM_TERMS);
    localparam logic [P_WIDTH_IN-1:0] c_num_one = P_WIDTH_IN'(1);

    state_t                state_q,  state_d;
    logic [17:0]           acc_q,    acc_d;
    logic [15:0]           k_q,      k_d;
    logic [P_WIDTH_IN-1:0] term_q,   term_d;
    logic [P_WIDTH_IN-1:0] num_q,    num_d;
    logic [P_WIDTH_IN-1:0] den_q,    den_d;
    logic [18:0]           pi_q,     pi_d;
    logic                  busy_q,   busy_d;
    logic                  done_q,   done_d;

    // Odd denominator 2k+1; k never exceeds 32767 when a division is issued
    function automatic logic [P_WIDTH_IN-1:0] den_of(input logic [15:0] k);
        logic [15:0] w_den;
        w_den  = {k[14:0], 1'b1};
        return P_WIDTH_IN'(w_den);
    endfunction

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        k_d     = k_q;
        term_d  = term_q;
        num_d   = num_q;
        den_d   = den_q;
        pi_d    = pi_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = c_acc_one;
                    k_d     = 16'd1;
                    num_d   = c_num_one;
                    den_d   = den_of(16'd1);
                    state_d = (P_NUM_TERMS == 1) ? S_FINISH : S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Hold here until the previous done level has dropped
                if (!div_if.div_done) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (div_if.div_done) begin
                    term_d  = div_if.div_decimal;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                acc_d = k_q[0] ? (acc_q - 18'(term_q)) : (acc_q + 18'(term_q));
                k_d   = k_q + 16'd1;
                if (k_d == c_last_k) begin
                    state_d = S_FINISH;
                end else begin
                    den_d   = den_of(k_d);
                    state_d = S_ISSUE;
                end
            end
            S_FINISH: begin
                num_d   = '0;
                den_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Q1.16 pi/4 times four is a two-bit left shift into Q3.16
        if (state_d == S_FINISH) begin
            pi_d = {acc_d[16:0], 2'b00};
        end
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FINISH);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            k_q     <= '0;
            term_q  <= '0;
            num_q   <= '0;
            den_q   <= '0;
            pi_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            term_q  <= term_d;
            num_q   <= num_d;
            den_q   <= den_d;
            pi_q    <= pi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Start is decoded from the ISSUE state so the pulse lands in that cycle
    // and is structurally excluded while the divider still shows done.
    assign div_if.div_start       = (state_q == S_ISSUE) && !div_if.div_done;
    assign div_if.div_numerator   = num_q;
    assign div_if.div_denominator = den_q;

    assign busy     = busy_q;
    assign done     = done_q;
    assign pi_out   = pi_q;
    assign term_idx = k_q;

endmodule
`default_nettype wire

// File: tb/tb_pi_leibniz_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pi_leibniz_sequencer
//  Description : Three sequencer lanes (N = 1, 3, 100), each driving a
//                behavioural divider with random latency and done-hold,
//                compared every cycle against a series-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pi_leibniz_sequencer;

    localparam int c_lanes   = 3;
    localparam int c_nt [3]  = '{1, 3, 100};
    localparam int c_timeout = 20000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic [2:0]          start;
    logic [2:0]          busy, done, ds, dd;
    logic [2:0][18:0]    pi_out;
    logic [2:0][15:0]    term_idx, num, den, dec;

    int checks = 0;
    int errors = 0;
    int tmo_req = 0;
    int tmo_seen = 0;

    for (genvar gi = 0; gi < c_lanes; gi++) begin : g_lane
        pi_leibniz_sequencer_if #(.P_WIDTH_IN(16)) ifc ();

        pi_leibniz_sequencer #(
            .P_WIDTH_IN  (16),
            .P_NUM_TERMS (c_nt[gi])
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (start[gi]),
            .busy     (busy[gi]),
            .done     (done[gi]),
            .pi_out   (pi_out[gi]),
            .term_idx (term_idx[gi]),
            .div_if   (ifc)
        );

        assign ds[gi]          = ifc.div_start;
        assign num[gi]         = ifc.div_numerator;
        assign den[gi]         = ifc.div_denominator;
        assign ifc.div_done    = dd[gi];
        assign ifc.div_decimal = dec[gi];
    end

    // ---------------- behavioural calc_decimal ----------------
    int lat [3];
    int hold [3];
    int op_num [3];
    int op_den [3];

    function automatic logic [15:0] quot(input int n, input int d);
        if (d == 0) return 16'hFFFF;
        return 16'((n * 65536) / d);
    endfunction

    always @(posedge clk) begin
        for (int l = 0; l < c_lanes; l++) begin
            if (!rst_n) begin
                lat[l]  <= 0;
                hold[l] <= 0;
                dd[l]   <= 1'b0;
                dec[l]  <= '0;
            end else if (ds[l]) begin
                lat[l]    <= int'($urandom_range(1, 5));
                op_num[l] <= int'(num[l]);
                op_den[l] <= int'(den[l]);
            end else if (lat[l] > 0) begin
                lat[l] <= lat[l] - 1;
                if (lat[l] == 1) begin
                    dd[l]   <= 1'b1;
                    dec[l]  <= quot(op_num[l], op_den[l]);
                    hold[l] <= int'($urandom_range(0, 2));
                end
            end else if (hold[l] > 0) begin
                hold[l] <= hold[l] - 1;
            end else begin
                dd[l] <= 1'b0;
            end
        end
    end

    // ---------------- series-level reference ----------------
    function automatic int pi_model(input int n);
        int acc;
        acc = 65536;
        for (int k = 1; k < n; k++) begin
            if (k % 2 == 1) acc -= 65536 / (2 * k + 1);
            else            acc += 65536 / (2 * k + 1);
        end
        return (acc & 'h1FFFF) << 2;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- single compare process ----------------
    bit          active [3]     = '{default: 1'b0};
    bit          in_wait [3]    = '{default: 1'b0};
    bit          issue_pend [3] = '{default: 1'b0};
    bit          rst_pend [3]   = '{default: 1'b0};
    int          issue_due [3]  = '{default: -1};
    int          done_due [3]   = '{default: -1};
    int          cur_k [3]      = '{default: 0};
    int          pulses [3]     = '{default: 0};
    int          prev_tidx [3]  = '{default: 0};
    logic [18:0] last_pi [3]    = '{default: '0};
    int          cyc = 0;
    bit          was_active, exp_ds, exp_done;
    int          diff;

    always @(negedge clk) begin
        cyc++;
        while (tmo_seen < tmo_req) begin
            tmo_seen++;
            check("wait_for_done_timeout", 32'd1, 32'd0);
        end
        for (int l = 0; l < c_lanes; l++) begin
            was_active = active[l];
            if (rst_pend[l]) begin
                rst_pend[l] = 1'b0;
                check($sformatf("lane%0d_rst_busy", l), busy[l], 0);
                check($sformatf("lane%0d_rst_done", l), done[l], 0);
                check($sformatf("lane%0d_rst_pi", l), pi_out[l], 0);
                check($sformatf("lane%0d_rst_tidx", l), term_idx[l], 0);
                check($sformatf("lane%0d_rst_dstart", l), ds[l], 0);
                check($sformatf("lane%0d_rst_num", l), num[l], 0);
                check($sformatf("lane%0d_rst_den", l), den[l], 0);
            end
            if (active[l]) begin
                check($sformatf("lane%0d_busy", l), busy[l], 1);
                check($sformatf("lane%0d_tidx_monotone", l), 32'(term_idx[l] >= 16'(prev_tidx[l])), 1);
                prev_tidx[l] = int'(term_idx[l]);
                exp_ds = issue_pend[l] && (cyc >= issue_due[l]) && !dd[l];
                check($sformatf("lane%0d_div_start", l), ds[l], 32'(exp_ds));
                if (exp_ds) begin
                    check($sformatf("lane%0d_issue_den", l), den[l], 32'(2 * cur_k[l] + 1));
                    check($sformatf("lane%0d_issue_num", l), num[l], 1);
                    check($sformatf("lane%0d_issue_tidx", l), term_idx[l], 32'(cur_k[l]));
                    issue_pend[l] = 1'b0;
                    in_wait[l]    = 1'b1;
                    pulses[l]++;
                end else if (in_wait[l]) begin
                    check($sformatf("lane%0d_wait_den_stable", l), den[l], 32'(2 * cur_k[l] + 1));
                    check($sformatf("lane%0d_wait_num_stable", l), num[l], 1);
                    if (dd[l]) begin
                        in_wait[l] = 1'b0;
                        if (cur_k[l] + 1 == c_nt[l]) begin
                            done_due[l] = cyc + 2;
                        end else begin
                            issue_pend[l] = 1'b1;
                            issue_due[l]  = cyc + 2;
                            cur_k[l]++;
                        end
                    end
                end
                exp_done = (cyc == done_due[l]);
                check($sformatf("lane%0d_done", l), done[l], 32'(exp_done));
                if (exp_done) begin
                    check($sformatf("lane%0d_pi_model", l), pi_out[l], 32'(pi_model(c_nt[l])));
                    check($sformatf("lane%0d_div_pulses", l), 32'(pulses[l]), 32'(c_nt[l] - 1));
                    if (l == 0) check("lane0_pi_literal", pi_out[l], 32'h40000);
                    if (l == 1) check("lane1_pi_literal", pi_out[l], 32'h37778);
                    if (l == 2) begin
                        diff = int'(pi_out[l]) - 'h3243F;
                        if (diff < 0) diff = -diff;
                        check("lane2_pi_error_bound", 32'(diff <= 721), 1);
                    end
                    last_pi[l]  = 19'(pi_model(c_nt[l]));
                    active[l]   = 1'b0;
                    done_due[l] = -1;
                end
            end else begin
                check($sformatf("lane%0d_idle_busy", l), busy[l], 0);
                check($sformatf("lane%0d_idle_done", l), done[l], 0);
                check($sformatf("lane%0d_idle_dstart", l), ds[l], 0);
                check($sformatf("lane%0d_idle_pi_hold", l), pi_out[l], 32'(last_pi[l]));
            end
            if (!was_active && start[l] && rst_n) begin
                active[l]    = 1'b1;
                cur_k[l]     = 1;
                pulses[l]    = 0;
                prev_tidx[l] = 0;
                in_wait[l]   = 1'b0;
                if (c_nt[l] == 1) begin
                    done_due[l] = cyc + 1;
                end else begin
                    issue_pend[l] = 1'b1;
                    issue_due[l]  = cyc + 1;
                end
            end
            if (!rst_n) begin
                rst_pend[l]   = 1'b1;
                active[l]     = 1'b0;
                in_wait[l]    = 1'b0;
                issue_pend[l] = 1'b0;
                done_due[l]   = -1;
                last_pi[l]    = '0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse(input int l);
        @(posedge clk); #2 start[l] = 1'b1;
        @(posedge clk); #2 start[l] = 1'b0;
    endtask

    task automatic wait_done(input int l);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < c_timeout && !seen; i++) begin
            @(negedge clk);
            if (done[l]) seen = 1'b1;
        end
        if (!seen) tmo_req++;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        bit hit;
        rst_n = 1'b0;
        start = 3'b111;
        repeat (2) @(posedge clk);
        #2 start = 3'b000;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        pulse(0); wait_done(0);
        for (int r = 0; r < 4; r++) begin
            pulse(1); wait_done(1);
        end

        // repeated start while busy must be ignored
        pulse(2);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #2 start[2] = 1'($urandom_range(0, 1));
        end
        #0 start[2] = 1'b0;
        wait_done(2);

        // reset during WAIT of term k=5
        pulse(2);
        hit = 1'b0;
        for (int i = 0; i < c_timeout && !hit; i++) begin
            @(negedge clk);
            if (ds[2] && den[2] == 16'd11) hit = 1'b1;
        end
        if (!hit) tmo_req++;
        @(posedge clk); #2 rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        pulse(1); wait_done(1);
        pulse(0); wait_done(0);
        pulse(2); wait_done(2);

        repeat (4) @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
